// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Data-memory responder for the CPU load/store port. Accepts one
//               request, waits WAIT_CYCLES, performs a byte/half/word access
//               on an internal word array and pulses one response.
//               Optional store logging: define DM_WRITE_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int         c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_busy;
    logic [31:0] r_mem [c_DEPTH];

    logic                  w_access;
    logic                  w_err;
    logic                  w_commit;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;
    logic [3:0]            w_bmask;
    logic [31:0]           w_wshift;
    logic [31:0]           w_merged;

    assign w_index  = r_addr[DEPTH_LOG2+1:2];
    assign w_word   = r_mem[w_index];
    assign w_access = (r_state == S_WAIT) && (r_count == 4'd0);
    assign w_commit = w_access && r_we && !w_err;

    always_comb begin
        w_err = 1'b0;
        case (r_size)
            2'd1:    w_err = r_addr[0];
            2'd2:    w_err = |r_addr[1:0];
            2'd3:    w_err = 1'b1;
            default: w_err = 1'b0;
        endcase
        // Any address bit above the word index means the access is out of range.
        if (|r_addr[31:DEPTH_LOG2+2]) w_err = 1'b1;
    end

    always_comb begin
        w_byte = w_word[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_size)
            2'd0:    w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
        case (r_size)
            2'd0:    w_bmask = 4'b0001 << r_addr[1:0];
            2'd1:    w_bmask = 4'b0011 << {r_addr[1], 1'b0};
            default: w_bmask = 4'b1111;
        endcase
        w_wshift = r_wdata << {r_addr[1:0], 3'b000};
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_merged[8*gi +: 8] = w_bmask[gi] ? w_wshift[8*gi +: 8] : w_word[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_index] <= w_merged;
`ifdef DM_WRITE_LOG_EN
            $display("%d@%h: *%h <= %h", $time, r_pc, {r_addr[31:2], 2'b00}, w_merged);
`endif
        end
    end

`ifndef DM_WRITE_LOG_EN
    logic w_unused_pc;
    assign w_unused_pc = ^r_pc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_count      <= 4'd0;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_pc         <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_pc        <= req_pc;
                        r_count     <= c_WAIT_INIT;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_resp_err   <= w_err;
                        r_resp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the memory end of the pipelined CPU's load/store port.
- Accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, then performs the byte/half/word access on an internal word array and returns one response pulse.
- The CPU's MEM stage stalls on `req_ready`/`resp_valid`.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KiB).
- WAIT_CYCLES, 2, wait states between accept and access, range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_pc  in  32  PC of the issuing instruction; used only for logging
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request was misaligned, out of range or illegal size
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (reset=0, async):
  - state=IDLE, counter=0, request latches cleared.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - Memory array contents are not reset.
- IDLE:
  - req_ready=1.
  - Accept on the rising edge where req_valid&&req_ready: latch we/size/signed/addr/wdata/pc, load counter=WAIT_CYCLES, go to WAIT.
- WAIT:
  - req_ready=0, busy=1.
  - Each edge with counter!=0 decrements the counter.
  - On the edge with counter==0: perform the access, register resp_rdata/resp_err, go to RESP.
  - With WAIT_CYCLES=0 this happens on the edge after accept.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0 in RESP; a new request can be accepted earliest the cycle after RESP.
- Latency: accept at edge E0 -> resp_valid high in the cycle after edge E0+WAIT_CYCLES+1.
- resp_rdata/resp_err keep their values until the next RESP.
- Request inputs are ignored while not in IDLE; changes after accept have no effect.
- Error conditions:
  - size==3;
  - half with addr[0]!=0;
  - word with addr[1:0]!=0;
  - addr[31:2] >= 2^DEPTH_LOG2.
  - On error: no memory write, resp_err=1, resp_rdata=0, same latency.
- Word index = addr[DEPTH_LOG2+1:2]; lane = addr[1:0].
- Stores are read-modify-write of one word:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes bytes addr[1]*2 .. +1 with wdata[15:0];
  - word writes the whole word;
  - other bytes are unchanged.
- Loads: select the lane by address, then sign- or zero-extend to 32 bits per req_signed. Word loads ignore req_signed.
- Reset mid-operation: returns to IDLE immediately, no response pulse, and any pending store is dropped. The access point is after WAIT, so a pending store has not been written.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- Defined: on each committed (non-error) store, in the access cycle, print via $display: "<time>@<req_pc hex>: *<word-aligned byte address hex> <= <full merged 32-bit word hex>". Format is `%d@%h: *%h <= %h`, address padded to 8 hex digits.
- Undefined: no simulation output; RTL otherwise identical. req_pc is still a port and is left unused.

Test Plan:
- Reset asserted mid-WAIT of a store sw 0x12345678 @0x10 -> no resp_valid, req_ready=1 immediately; a later lw @0x10 does not return 0x12345678.
- WAIT_CYCLES=2: sw 0xDEADBEEF @0x20 accepted at edge 0 -> resp_valid high only in the cycle after edge 3, resp_err=0, resp_rdata=0; then lw @0x20 -> 0xDEADBEEF with the same latency.
- Byte lanes: sw 0x00000000 @0x40; sb 0x80 @0x42 -> lb @0x42 returns 0xFFFFFF80, lbu returns 0x00000080, lw @0x40 returns 0x00800000.
- Halves: sh 0xABCD @0x46 on 0x11223344 -> lw @0x44 returns 0xABCD3344; lh @0x46 returns 0xFFFFABCD; lhu returns 0x0000ABCD.
- Errors:
  - lw @0x22 -> resp_err=1, resp_rdata=0;
  - sh @0x21 -> resp_err=1 and memory unchanged;
  - sw @0x00001000 with DEPTH_LOG2=10 -> resp_err=1;
  - size=3 -> resp_err=1.
- Handshake: req_valid held high continuously with changing addr during WAIT/RESP -> exactly one accept per IDLE cycle; the response reflects the address latched at accept.
- With DM_WRITE_LOG_EN defined: the sb case above prints "...@<pc>: *00000040 <= 00800000".
